// File: rtl/dense_4_argmax_out.sv
// Argmax output stage for dense_4: a serial scan, one logit per cycle, returning class, max, margin and confidence.
// Latency: out_valid is seen at the N_CLASSES+1'th rising edge after acceptance; one vector in flight, II >= N_CLASSES+2.
// Backpressure: the result is held stable in DONE until out_ready; in_ready stays low from acceptance until the result is taken.
module dense_4_argmax_out #(
  parameter int               WIDTH         = 23,
  parameter int               NFRAC         = 11,
  parameter int               N_CLASSES     = 5,
  parameter logic [WIDTH-1:0] MARGIN_THRESH = 23'd205
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_CLASSES*WIDTH-1:0]   in_logits,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2:0]                   out_class,
  output logic [WIDTH-1:0]             out_max,
  output logic [WIDTH-1:0]             out_margin,
  output logic                         out_low_conf
);

  // Logits are Q(WIDTH-NFRAC).NFRAC and pass through untouched; only the legal range matters here.
  if (N_CLASSES < 2 || N_CLASSES > 8 || NFRAC >= WIDTH) begin : g_param_err
    $error("dense_4_argmax_out: N_CLASSES must be 2..8 and NFRAC < WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [2:0]              LAST_IDX = 3'(N_CLASSES - 1);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                      state, state_nxt;
  logic [N_CLASSES*WIDTH-1:0]  logits_q;
  logic [2:0]                  idx;
  logic signed [WIDTH-1:0]     best, second, cur;
  logic signed [WIDTH-1:0]     best_nxt, second_nxt;
  logic [2:0]                  best_idx, best_idx_nxt;
  logic [WIDTH:0]              best_ext, second_ext;
  logic [WIDTH-1:0]            margin_val;
  logic                        accept, last_step, release_out;

  // State register; reset drops any vector in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, walk N_CLASSES cycles in SCAN, wait for the consumer in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = SCAN;
      SCAN:    if (last_step)   state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready is forced low while reset is held.
  always_comb begin
    in_ready    = (state == IDLE) && rst_n;
    out_valid   = (state == DONE);
    accept      = in_valid && in_ready;
    last_step   = (state == SCAN) && (idx == LAST_IDX);
    release_out = out_valid && out_ready;
  end

  // One compare step: strict greater-than on best keeps the lower index on ties,
  // while the second compare lets an equal logit land in second so ties give margin 0.
  always_comb begin
    cur          = $signed(logits_q[idx*WIDTH +: WIDTH]);
    best_nxt     = best;
    second_nxt   = second;
    best_idx_nxt = best_idx;
    if (idx == 3'd0) begin
      best_nxt     = cur;
      second_nxt   = MOST_NEG;
      best_idx_nxt = 3'd0;
    end else if (cur > best) begin
      second_nxt   = best;
      best_nxt     = cur;
      best_idx_nxt = idx;
    end else if (cur > second) begin
      second_nxt   = cur;
    end
  end

  // Margin at WIDTH+1 bits is always in [0, 2^WIDTH-1], so its low WIDTH bits are exact.
  always_comb begin
    best_ext   = {best_nxt[WIDTH-1], best_nxt};
    second_ext = {second_nxt[WIDTH-1], second_nxt};
    margin_val = WIDTH'(best_ext - second_ext);
  end

  // Scan datapath: capture the vector on acceptance, then fold one logit per SCAN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      logits_q <= '0;
      idx      <= '0;
      best     <= '0;
      second   <= '0;
      best_idx <= '0;
    end else if (accept) begin
      logits_q <= in_logits;
      idx      <= '0;
    end else if (state == SCAN) begin
      best     <= best_nxt;
      second   <= second_nxt;
      best_idx <= best_idx_nxt;
      idx      <= last_step ? 3'd0 : idx + 3'd1;
    end
  end

  // Result registers load on the final scan step and otherwise hold, including after out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_class    <= '0;
      out_max      <= '0;
      out_margin   <= '0;
      out_low_conf <= 1'b0;
    end else if (last_step) begin
      out_class    <= best_idx_nxt;
      out_max      <= best_nxt;
      out_margin   <= margin_val;
      out_low_conf <= (margin_val < MARGIN_THRESH);
    end
  end

endmodule
